// File: rtl/fsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fsub_seq
//  Description : Multi-cycle FP32 subtractor (a - b), bit-serial align/normalize,
//                truncating, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsub_seq #(
    parameter int ALIGN_LIMIT = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        special
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_SUB   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    state_t      r_state, w_nxt_state;
    logic        r_sa, r_sb, r_sn, r_pend, r_special;
    logic [8:0]  r_ea, r_eb, r_en;
    logic [23:0] r_ma, r_mb, r_mn;
    logic [31:0] r_result;

    logic        w_nxt_sa, w_nxt_sb, w_nxt_sn, w_nxt_pend, w_nxt_special;
    logic [8:0]  w_nxt_ea, w_nxt_eb, w_nxt_en;
    logic [23:0] w_nxt_ma, w_nxt_mb, w_nxt_mn;
    logic [31:0] w_nxt_result;

    // Operand unpack
    logic [7:0]  w_fa, w_fb;
    logic [8:0]  w_ea_u, w_eb_u, w_d;
    logic [23:0] w_ma_u, w_mb_u;
    logic        w_a_ge, w_far, w_is_spc;

    assign w_fa     = a[30:23];
    assign w_fb     = b[30:23];
    assign w_ea_u   = (w_fa == 8'd0) ? 9'd1 : {1'b0, w_fa};
    assign w_eb_u   = (w_fb == 8'd0) ? 9'd1 : {1'b0, w_fb};
    assign w_ma_u   = {(w_fa != 8'd0), a[22:0]};
    assign w_mb_u   = {(w_fb != 8'd0), b[22:0]};
    assign w_a_ge   = (w_ea_u >= w_eb_u);
    assign w_d      = w_a_ge ? (w_ea_u - w_eb_u) : (w_eb_u - w_ea_u);
    assign w_far    = (w_d >= 9'(ALIGN_LIMIT));
    assign w_is_spc = (w_fa == 8'hFF) || (w_fb == 8'hFF);

    // Signed-magnitude add of the aligned mantissas
    logic [24:0] w_add, w_dif, w_mag;
    logic [23:0] w_mag_n;
    logic [8:0]  w_exp_n, w_ea_inc, w_eb_inc;
    logic        w_a_big, w_sgn;

    assign w_ea_inc = r_ea + 9'd1;
    assign w_eb_inc = r_eb + 9'd1;
    assign w_add    = {1'b0, r_ma} + {1'b0, r_mb};
    assign w_a_big  = (r_ma >= r_mb);
    assign w_dif    = w_a_big ? ({1'b0, r_ma} - {1'b0, r_mb})
                              : ({1'b0, r_mb} - {1'b0, r_ma});
    assign w_mag    = (r_sa == r_sb) ? w_add : w_dif;
    assign w_sgn    = (r_sa == r_sb) ? r_sa : (w_a_big ? r_sa : r_sb);
    assign w_mag_n  = w_mag[24] ? w_mag[24:1] : w_mag[23:0];
    assign w_exp_n  = r_ea + {8'd0, w_mag[24]};

    // Normalization step and packing
    logic [23:0] w_mn_sh;
    logic [8:0]  w_en_dec;
    logic        w_norm_ok, w_sh_ok;
    logic [31:0] w_pack_now, w_pack_sh;

    assign w_mn_sh    = {r_mn[22:0], 1'b0};
    assign w_en_dec   = r_en - 9'd1;
    assign w_norm_ok  = r_mn[23] || (r_en == 9'd1);
    assign w_sh_ok    = w_mn_sh[23] || (w_en_dec == 9'd1);
    assign w_pack_now = {r_sn, (r_mn[23] ? r_en[7:0] : 8'd0), r_mn[22:0]};
    assign w_pack_sh  = {r_sn, (w_mn_sh[23] ? w_en_dec[7:0] : 8'd0), w_mn_sh[22:0]};

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_sa      = r_sa;
        w_nxt_sb      = r_sb;
        w_nxt_sn      = r_sn;
        w_nxt_pend    = r_pend;
        w_nxt_ea      = r_ea;
        w_nxt_eb      = r_eb;
        w_nxt_en      = r_en;
        w_nxt_ma      = r_ma;
        w_nxt_mb      = r_mb;
        w_nxt_mn      = r_mn;
        w_nxt_result  = r_result;
        w_nxt_special = r_special;
        in_ready      = 1'b0;
        out_valid     = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nxt_sa    = a[31];
                    w_nxt_sb    = ~b[31];
                    w_nxt_ea    = w_ea_u;
                    w_nxt_eb    = w_eb_u;
                    w_nxt_ma    = w_ma_u;
                    w_nxt_mb    = w_mb_u;
                    w_nxt_pend  = w_is_spc;
                    w_nxt_state = S_ALIGN;
                    if (!w_is_spc && w_far) begin
                        if (w_a_ge) begin
                            w_nxt_mb = 24'd0;
                            w_nxt_eb = w_ea_u;
                        end else begin
                            w_nxt_ma = 24'd0;
                            w_nxt_ea = w_eb_u;
                        end
                    end
                end
            end
            S_ALIGN: begin
                // A NaN/Inf operand spends one cycle here so its latency is one cycle
                if (r_pend) begin
                    w_nxt_result  = c_QNAN;
                    w_nxt_special = 1'b1;
                    w_nxt_state   = S_DONE;
                end else if (r_ea == r_eb) begin
                    w_nxt_state = S_SUB;
                end else if (r_ea < r_eb) begin
                    w_nxt_ma = r_ma >> 1;
                    w_nxt_ea = w_ea_inc;
                    if (w_ea_inc == r_eb) w_nxt_state = S_SUB;
                end else begin
                    w_nxt_mb = r_mb >> 1;
                    w_nxt_eb = w_eb_inc;
                    if (w_eb_inc == r_ea) w_nxt_state = S_SUB;
                end
            end
            S_SUB: begin
                w_nxt_special = 1'b0;
                if (w_exp_n == 9'd255) begin
                    w_nxt_result = {w_sgn, 8'hFF, 23'd0};
                    w_nxt_state  = S_DONE;
                end else if (w_mag == 25'd0) begin
                    w_nxt_result = 32'd0;
                    w_nxt_state  = S_DONE;
                end else begin
                    w_nxt_sn    = w_sgn;
                    w_nxt_en    = w_exp_n;
                    w_nxt_mn    = w_mag_n;
                    w_nxt_state = S_NORM;
                end
            end
            S_NORM: begin
                if (w_norm_ok) begin
                    w_nxt_result = w_pack_now;
                    w_nxt_state  = S_DONE;
                end else begin
                    w_nxt_mn = w_mn_sh;
                    w_nxt_en = w_en_dec;
                    if (w_sh_ok) begin
                        w_nxt_result = w_pack_sh;
                        w_nxt_state  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_nxt_state = S_IDLE;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_sn      <= 1'b0;
            r_pend    <= 1'b0;
            r_ea      <= 9'd0;
            r_eb      <= 9'd0;
            r_en      <= 9'd0;
            r_ma      <= 24'd0;
            r_mb      <= 24'd0;
            r_mn      <= 24'd0;
            r_result  <= 32'd0;
            r_special <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_sa      <= w_nxt_sa;
            r_sb      <= w_nxt_sb;
            r_sn      <= w_nxt_sn;
            r_pend    <= w_nxt_pend;
            r_ea      <= w_nxt_ea;
            r_eb      <= w_nxt_eb;
            r_en      <= w_nxt_en;
            r_ma      <= w_nxt_ma;
            r_mb      <= w_nxt_mb;
            r_mn      <= w_nxt_mn;
            r_result  <= w_nxt_result;
            r_special <= w_nxt_special;
        end
    end

    assign result  = r_result;
    assign special = r_special;

endmodule
`default_nettype wire

// File: tb/tb_fsub_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsub_seq
//  Description : Scoreboard bench for fsub_seq against an arithmetic FP model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsub_seq;

    localparam int c_ALIGN_LIMIT = 26;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        special;

    fsub_seq #(.ALIGN_LIMIT(c_ALIGN_LIMIT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .special   (special)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        logic        spc;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   hold_ready = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: exact a - b on integer mantissas, aligned with truncation.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] res, output logic spc, output int lat);
        int     fa, fb, ea, eb, d, e, ed, n;
        longint ma, mb, sum, mag;
        logic   neg;
        fa = int'(av[30:23]);
        fb = int'(bv[30:23]);
        if (fa == 255 || fb == 255) begin
            res = 32'h7FC0_0000; spc = 1'b1; lat = 1;
            return;
        end
        spc = 1'b0;
        ea = (fa == 0) ? 1 : fa;
        eb = (fb == 0) ? 1 : fb;
        ma = longint'(av[22:0]); if (fa != 0) ma += 8388608;
        mb = longint'(bv[22:0]); if (fb != 0) mb += 8388608;
        d  = (ea > eb) ? ea - eb : eb - ea;
        e  = (ea > eb) ? ea : eb;
        ed = (d == 0 || d >= c_ALIGN_LIMIT) ? 1 : d;
        if (ea > eb) mb = (d >= c_ALIGN_LIMIT) ? 0 : (mb >> d);
        if (eb > ea) ma = (d >= c_ALIGN_LIMIT) ? 0 : (ma >> d);
        sum = (av[31] ? -ma : ma) - (bv[31] ? -mb : mb);
        if (sum == 0) begin
            res = 32'd0; lat = ed + 1;
            return;
        end
        neg = (sum < 0);
        mag = neg ? -sum : sum;
        if (mag >= 16777216) begin
            mag = mag >> 1;
            e++;
        end
        if (e == 255) begin
            res = {neg, 8'hFF, 23'd0}; lat = ed + 1;
            return;
        end
        n = 0;
        while (mag < 8388608 && e > 1) begin
            mag = mag << 1;
            e--;
            n++;
        end
        res = {neg, ((mag >= 8388608) ? 8'(e) : 8'd0), 23'(mag)};
        lat = ed + 1 + ((n == 0) ? 1 : n);
    endfunction

    // Issue one operation; expected values come from the model or the caller.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit use_model,
                         input logic [31:0] xres, input logic xspc, input int xlat);
        exp_t e;
        int   guard = 0;
        logic [31:0] mres;
        logic        mspc;
        int          mlat;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        a = av; b = bv; in_valid = 1'b1;
        if (use_model) begin
            model(av, bv, mres, mspc, mlat);
            e.res = mres; e.spc = mspc; e.lat = mlat;
        end else begin
            e.res = xres; e.spc = xspc; e.lat = xlat;
        end
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_a();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 9))
            0:       r[30:23] = 8'd0;
            1:       r[30:23] = 8'hFF;
            2:       r[30:23] = 8'hFE;
            default: r[30:23] = 8'($urandom_range(90, 165));
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_b(input logic [31:0] av);
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0:       ;
            1:       r[30:23] = av[30:23];
            2, 3:    r[30:23] = av[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
            4:       r[30:23] = 8'd0;
            default: r[30:0]  = av[30:0];
        endcase
        return r;
    endfunction

    // Monitor / consumer
    initial begin : monitor
        bit          seen = 1'b0;
        logic [31:0] held_r;
        logic        held_s;
        exp_t        e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen      = 1'b0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", result, e.res);
                        check("special", 32'(special), 32'(e.spc));
                        check("latency", 32'(cyc), 32'(e.acc + e.lat));
                    end
                    seen   = 1'b1;
                    held_r = result;
                    held_s = special;
                end else begin
                    check("hold_result", result, held_r);
                    check("hold_special", 32'(special), 32'(held_s));
                    check("hold_in_ready", 32'(in_ready), 32'd0);
                end
                out_ready = hold_ready ? 1'b0 : (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
                if (out_ready) seen = 1'b0;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] res;
        logic        spc;
        int          lat;
    } dir_t;

    initial begin : stim
        dir_t dirs[10];
        int   g;
        dirs[0] = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3};
        dirs[1] = '{32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 1'b0, 4};
        dirs[2] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 2};
        dirs[3] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 3};
        dirs[4] = '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b0, 2};
        dirs[5] = '{32'h7F80_0000, 32'h1234_5678, 32'h7FC0_0000, 1'b1, 1};
        dirs[6] = '{32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 1'b0, 26};
        dirs[7] = '{32'h4B80_0000, 32'h3380_0000, 32'h4B80_0000, 1'b0, 3};
        dirs[8] = '{32'h0080_0000, 32'h0040_0000, 32'h0040_0000, 1'b0, 3};
        dirs[9] = '{32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1, 1};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_special", 32'(special), 32'd0);
        rst_n = 1'b1;

        foreach (dirs[i]) begin
            issue(dirs[i].av, dirs[i].bv, 1'b0, dirs[i].res, dirs[i].spc, dirs[i].lat);
            drain();
        end

        // Back-pressure with in_valid pulses during DONE
        hold_ready = 1'b1;
        issue(32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 3);
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a = $urandom;
            b = $urandom;
        end
        in_valid = 1'b0;
        hold_ready = 1'b0;
        g = 0;
        while (out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_in_ready", 32'(in_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("bp_no_second", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of ALIGN
        issue(32'h4B80_0000, 32'h3F80_0000, 1'b0, 32'h4B80_0000, 1'b0, 26);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_result", result, 32'd0);
        check("arst_special", 32'(special), 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(32'h3F80_0000, 32'h3F40_0000, 1'b0, 32'h3E80_0000, 1'b0, 4);
        drain();

        // Randomized back-to-back traffic with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = rand_a();
            rb = rand_b(ra);
            issue(ra, rb, 1'b1, 32'd0, 1'b0, 0);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
